// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and FSM encoding for the register-file write scheduler.
// Also provides the fixed-priority grant helper that both arbitration builds use.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } wr_state_e;

  // Grant for zero or one valid requester; contention resolves to req0.
  function automatic logic [1:0] fixed_prio(input logic [1:0] valid);
    logic [1:0] grant;
    grant = 2'b00;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
    return grant;
  endfunction

endpackage

// File: rtl/regfile_write_sched_arb.sv
// rr_arb2: two-input round-robin arbiter, combinational one-hot grant, no buffering.
// The pointer moves to the loser only after a contended grant; grant implies accept.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        grant_o = ptr_q ? 2'b10 : 2'b01;
        ptr_d   = ~ptr_q;
      end else begin
        grant_o = fixed_prio(valid_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: zero-sweep after reset, then one requester write per cycle, one-cycle latency.
// Build option RR_ARB_EN selects round-robin contention; otherwise req0 has fixed priority.
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [DATA_W-1:0] Req0Data,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              InitDone
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  wr_state_e         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic              reg_write_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              init_done_q;

  logic              arb_en;
  logic [1:0]        grant;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_writes;

  // Ready is forced low while reset is asserted so no handshake is claimed on an aborted cycle.
  assign arb_en = (state_q == ARB) && !reset;

`ifdef RR_ARB_EN
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (arb_en),
    .valid_i ({Req1Valid, Req0Valid}),
    .grant_o (grant)
  );
`else
  always_comb begin
    grant = 2'b00;
    if (arb_en) begin
      grant = fixed_prio({Req1Valid, Req0Valid});
    end
  end
`endif

  assign Req0Ready  = grant[0];
  assign Req1Ready  = grant[1];
  assign hs         = |grant;
  assign sel_addr   = grant[1] ? Req1Addr : Req0Addr;
  assign sel_data   = grant[1] ? Req1Data : Req0Data;
  // Register 0 is hard-wired zero after the sweep: accept but never write it.
  assign sel_writes = hs && (sel_addr != '0);
  assign clr_cnt_d  = clr_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (INIT_CLEAR != 0) ? CLEAR : ARB;
      init_done_q <= (INIT_CLEAR == 0);
      clr_cnt_q   <= '0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          reg_write_q <= 1'b1;
          wr_addr_q   <= clr_cnt_q;
          wr_data_q   <= '0;
          clr_cnt_q   <= clr_cnt_d;
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= ARB;
            init_done_q <= 1'b1;
          end
        end
        ARB: begin
          reg_write_q <= sel_writes;
          if (sel_writes) begin
            wr_addr_q <= sel_addr;
            wr_data_q <= sel_data;
          end
        end
        default: begin
          state_q     <= CLEAR;
          reg_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = wr_addr_q;
  assign WriteData     = wr_data_q;
  assign InitDone      = init_done_q;

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Sequences the single write port of the 32x32 register file and shares it between two writeback requesters: req0 = ALU/result path, req1 = load/multi-cycle unit.
- After reset, runs a clear sweep that writes zero to every register. It then arbitrates requests onto WriteRegister/WriteData/RegWrite, one write per cycle.
- Sits between the writeback sources and the register file write-port inputs.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- INIT_CLEAR, 1, 1 = run the zero-sweep after reset; 0 = go straight to arbitration

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- Req0Valid  in  1  requester 0 has a write pending
- Req0Ready  out  1  requester 0 write accepted this cycle (combinational from state/valids)
- Req0Addr  in  ADDR_W  requester 0 destination register
- Req0Data  in  DATA_W  requester 0 write data
- Req1Valid  in  1  requester 1 has a write pending
- Req1Ready  out  1  requester 1 write accepted this cycle
- Req1Addr  in  ADDR_W  requester 1 destination register
- Req1Data  in  DATA_W  requester 1 write data
- RegWrite  out  1  register file write enable (registered)
- WriteRegister  out  ADDR_W  register file write address (registered)
- WriteData  out  DATA_W  register file write data (registered)
- InitDone  out  1  high once the sweep is complete; stays high until the next reset

Behaviour:
- Clocking and reset: clk is the only clock. reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, InitDone=0, Req0Ready=Req1Ready=0, state=CLEAR (or ARB if INIT_CLEAR=0, with InitDone=1), ClrCnt=0, RR pointer=0 (req0 favoured first).
- Reset mid-operation: reset asserted in any state aborts immediately. The sweep restarts and any unissued grant is lost.
- State CLEAR:
  - Each cycle drives RegWrite=1, WriteRegister=ClrCnt, WriteData=0, then increments ClrCnt.
  - Both Ready outputs are held 0.
  - After the cycle with ClrCnt=2**ADDR_W-1, ClrCnt wraps to 0, state moves to ARB and InitDone rises.
  - The sweep takes exactly 32 write cycles; InitDone=1 on the 33rd cycle after reset release.
- State ARB, grant rules:
  - Exactly one handshake (Valid && Ready) per cycle at most.
  - Ready is asserted only to the granted requester, and only while its Valid is high.
  - Ready never asserts without the matching Valid.
  - Only one valid: that requester is granted.
  - Both valid: the RR pointer picks the winner. The pointer flips to the non-winner after every two-way contention grant. Single-requester grants leave the pointer unchanged.
- Latency: a handshake in cycle N produces RegWrite=1, WriteRegister=ReqAddr, WriteData=ReqData in cycle N+1, for exactly one cycle.
- No handshake in cycle N gives RegWrite=0 in N+1; WriteRegister/WriteData hold their last values.
- Register 0: a request with Addr=0 is accepted (Ready=1) but produces RegWrite=0 in the following cycle. Only the CLEAR sweep writes register 0.
- Same-address contention: both requesters targeting the same register is legal. Writes land in grant order; the later grant wins in the register file.
- Requester obligation: Valid, Addr and Data stay stable until Ready. The block does not buffer unaccepted requests.
- Throughput: sustained one write per cycle. With both requesters continuously valid, grants strictly alternate.

Optional Feature:
- RR_ARB_EN defined: round-robin arbitration as described above.
- RR_ARB_EN undefined: fixed priority, req0 always wins contention. The RR pointer logic is removed; req1 may starve under continuous req0 traffic.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, REG_ZERO=5'd0
  - state encoding typedef: CLEAR, ARB
- Natural sub-module: rr_arb2, the two-input arbiter (valids in, one-hot grant out, pointer update on accept), selected by RR_ARB_EN.
- The sweep counter and output registers remain in the top level.

Test Plan:
- Reset sweep: assert reset 2 cycles, release, Req0Valid=1 throughout -> 32 consecutive RegWrite=1 cycles with WriteRegister 0..31, WriteData=0. Req0Ready=0 throughout the sweep; InitDone=1 on cycle 33; first req0 write follows.
- Single write: after init, Req0Valid=1, Addr=5'd8, Data=32'hDEADBEEF for one cycle -> Req0Ready=1 that cycle. Next cycle RegWrite=1, WriteRegister=8, WriteData=32'hDEADBEEF; the cycle after, RegWrite=0.
- Contention with RR_ARB_EN: both valid for 4 cycles, req0 (Addr 1, Data 1), req1 (Addr 2, Data 2), held until accepted -> grants req0, req1, req0, req1. WriteRegister sequence 1, 2, 1, 2 in successive cycles.
- Contention without RR_ARB_EN: same stimulus -> req0 granted all 4 cycles, Req1Ready=0 throughout.
- Zero register: Req1Valid=1, Addr=0, Data=32'h12345678 -> Req1Ready=1, next cycle RegWrite=0.
- Mid-sweep reset: assert reset when ClrCnt=17 -> next cycle WriteRegister=0, InitDone=0. The full 32-cycle sweep reruns.
